// File: rtl/spi_mem_pkg.sv
// Shared constants and state encoding for the SPI memory responder.
// Opcodes, address length and the one-hot FSM state type.
package spi_mem_pkg;

   localparam logic [7:0] OP_READ  = 8'h03;
   localparam logic [7:0] OP_WRITE = 8'h02;

   localparam int ADDR_BYTES = 3;

   typedef enum logic [5:0] {
      S_IDLE   = 6'b000001,
      S_CMD    = 6'b000010,
      S_ADDR   = 6'b000100,
      S_RD     = 6'b001000,
      S_WR     = 6'b010000,
      S_IGNORE = 6'b100000
   } state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Pin synchronizer for sclk/cs_n/mosi with edge pulses.
// Edges are gated until the chain holds real post-reset samples.
module spi_pin_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sclk,
   input  logic cs_n,
   input  logic mosi,
   output logic mosi_s,
   output logic cs_n_s,
   output logic sclk_rise,
   output logic sclk_fall,
   output logic cs_fall
);
   import spi_mem_pkg::*;

   localparam int S = SYNC_STAGES;

   logic [S:0]   sclk_q, sclk_d;
   logic [S:0]   cs_q, cs_d;
   logic [S:0]   vld_q, vld_d;
   logic [S-1:0] mosi_q, mosi_d;

   always_comb begin
      sclk_d = {sclk_q[S-1:0], sclk};
      cs_d   = {cs_q[S-1:0], cs_n};
      vld_d  = {vld_q[S-1:0], 1'b1};
      mosi_d = {mosi_q[S-2:0], mosi};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sclk_q <= '0;
         cs_q   <= '1;
         vld_q  <= '0;
         mosi_q <= '0;
      end else begin
         sclk_q <= sclk_d;
         cs_q   <= cs_d;
         vld_q  <= vld_d;
         mosi_q <= mosi_d;
      end
   end

   assign mosi_s    = mosi_q[S-1];
   assign cs_n_s    = cs_q[S-1];
   assign sclk_rise = vld_q[S] & sclk_q[S-1] & ~sclk_q[S];
   assign sclk_fall = vld_q[S] & ~sclk_q[S-1] & sclk_q[S];
   assign cs_fall   = vld_q[S] & ~cs_q[S-1] & cs_q[S];

endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 target fronting a byte-wide synchronous memory.
// READ 0x03 / WRITE 0x02, 24-bit address, sequential auto-increment.
module spi_mem_responder #(
   parameter int ADDR_W      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sclk,
   input  logic              cs_n,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [7:0]        mem_rdata,
   output logic              busy,
   output logic              cmd_err
);
   import spi_mem_pkg::*;

   localparam int SH_W = (ADDR_W > 8) ? ADDR_W : 8;

   state_e            state_q, state_d;
   logic [2:0]        bit_q, bit_d;
   logic [1:0]        byte_q, byte_d;
   logic [SH_W-2:0]   sh_q, sh_d;
   logic [SH_W-1:0]   sh_nx;
   logic [7:0]        tx_q, tx_d;
   logic              rd_q, rd_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]        mem_wdata_q, mem_wdata_d;
   logic              mem_we_q, mem_we_d;
   logic              mem_re_q, mem_re_d;
   logic              re_dly_q, re_dly_d;
   logic              miso_q, miso_d;
   logic              cmd_err_q, cmd_err_d;

   logic mosi_s, cs_n_s, sclk_rise, sclk_fall, cs_fall;

   spi_pin_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .sclk     (sclk),
      .cs_n     (cs_n),
      .mosi     (mosi),
      .mosi_s   (mosi_s),
      .cs_n_s   (cs_n_s),
      .sclk_rise(sclk_rise),
      .sclk_fall(sclk_fall),
      .cs_fall  (cs_fall)
   );

   always_comb begin
      state_d     = state_q;
      bit_d       = bit_q;
      byte_d      = byte_q;
      sh_d        = sh_q;
      tx_d        = tx_q;
      rd_d        = rd_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_we_d    = 1'b0;
      mem_re_d    = 1'b0;
      re_dly_d    = mem_re_q;
      miso_d      = miso_q;
      cmd_err_d   = cmd_err_q;
      sh_nx       = {sh_q, mosi_s};

      unique case (state_q)
         S_IDLE: begin
            bit_d  = '0;
            byte_d = '0;
            miso_d = 1'b0;
            if (cs_fall) state_d = S_CMD;
         end
         S_CMD: begin
            if (sclk_rise) begin
               sh_d  = sh_nx[SH_W-2:0];
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  byte_d = '0;
                  if (sh_nx[7:0] == OP_READ) begin
                     rd_d    = 1'b1;
                     state_d = S_ADDR;
                  end else if (sh_nx[7:0] == OP_WRITE) begin
                     rd_d    = 1'b0;
                     state_d = S_ADDR;
                  end else begin
                     cmd_err_d = 1'b1;
                     state_d   = S_IGNORE;
                  end
               end
            end
         end
         S_ADDR: begin
            if (sclk_rise) begin
               sh_d  = sh_nx[SH_W-2:0];
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  byte_d = byte_q + 2'd1;
                  if (byte_q == 2'(ADDR_BYTES - 1)) begin
                     mem_addr_d = sh_nx[ADDR_W-1:0];
                     mem_re_d   = rd_q;
                     state_d    = rd_q ? S_RD : S_WR;
                  end
               end
            end
         end
         S_RD: begin
            if (re_dly_q) tx_d = mem_rdata;
            if (sclk_fall) begin
               miso_d = tx_q[7];
               tx_d   = {tx_q[6:0], 1'b0};
               bit_d  = bit_q + 3'd1;
               // prefetch so the next byte is loaded before its first fall
               if (bit_q == 3'd7) begin
                  mem_addr_d = mem_addr_q + ADDR_W'(1);
                  mem_re_d   = 1'b1;
               end
            end
         end
         S_WR: begin
            if (mem_we_q) mem_addr_d = mem_addr_q + ADDR_W'(1);
            if (sclk_rise) begin
               sh_d  = sh_nx[SH_W-2:0];
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  mem_wdata_d = sh_nx[7:0];
                  mem_we_d    = 1'b1;
               end
            end
         end
         S_IGNORE: begin
            miso_d = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase

      if (cs_n_s) begin
         state_d  = S_IDLE;
         mem_we_d = 1'b0;
         mem_re_d = 1'b0;
         miso_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         bit_q       <= '0;
         byte_q      <= '0;
         sh_q        <= '0;
         tx_q        <= '0;
         rd_q        <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_we_q    <= 1'b0;
         mem_re_q    <= 1'b0;
         re_dly_q    <= 1'b0;
         miso_q      <= 1'b0;
         cmd_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_q       <= bit_d;
         byte_q      <= byte_d;
         sh_q        <= sh_d;
         tx_q        <= tx_d;
         rd_q        <= rd_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_we_q    <= mem_we_d;
         mem_re_q    <= mem_re_d;
         re_dly_q    <= re_dly_d;
         miso_q      <= miso_d;
         cmd_err_q   <= cmd_err_d;
      end
   end

   assign miso_oe   = (state_q == S_RD);
   assign miso      = miso_q & miso_oe;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_we    = mem_we_q;
   assign mem_re    = mem_re_q;
   assign busy      = ~cs_n_s;
   assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_spi_mem_responder.sv
// Bench for spi_mem_responder: SPI initiator, byte memory and
// a flat-array reference of what memory should hold.
module tb_spi_mem_responder;

   localparam logic [7:0] OP_RD = 8'h03;
   localparam logic [7:0] OP_WR = 8'h02;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sclk;
   logic        cs_n;
   logic        mosi;
   logic        miso;
   logic        miso_oe;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic [7:0]  mem_rdata;
   logic        busy;
   logic        cmd_err;

   int total = 0;
   int bad   = 0;

   logic [7:0]  dev_mem [0:65535];
   logic [7:0]  ref_mem [0:65535];
   logic [23:0] wq [$];
   logic [7:0]  txq [$];
   logic [7:0]  rdq [$];
   int          re_cnt = 0;
   int          oe_cnt = 0;
   int          miso_bad = 0;

   spi_mem_responder dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sclk     (sclk),
      .cs_n     (cs_n),
      .mosi     (mosi),
      .miso     (miso),
      .miso_oe  (miso_oe),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_we   (mem_we),
      .mem_re   (mem_re),
      .mem_rdata(mem_rdata),
      .busy     (busy),
      .cmd_err  (cmd_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_re) mem_rdata <= dev_mem[mem_addr];
      if (mem_we) dev_mem[mem_addr] <= mem_wdata;
      if (mem_we) wq.push_back({mem_addr, mem_wdata});
      if (mem_re) re_cnt++;
      if (miso_oe) oe_cnt++;
      if (!miso_oe && miso) miso_bad++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic xfer(input logic [7:0] tx, input int nbits,
                       output logic [7:0] rx, output logic oe_any,
                       output logic oe_all);
      rx = '0;
      oe_any = 1'b0;
      oe_all = 1'b1;
      for (int i = 7; i >= 8 - nbits; i--) begin
         mosi = tx[i];
         repeat (4) @(posedge clk);
         #1;
         rx[i] = miso;
         oe_any = oe_any | miso_oe;
         oe_all = oe_all & miso_oe;
         sclk = 1'b1;
         repeat (4) @(posedge clk);
         #1;
         sclk = 1'b0;
      end
   endtask

   task automatic cs_start();
      cs_n = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic cs_end();
      repeat (8) @(posedge clk);
      #1 cs_n = 1'b1;
      mosi = 1'b0;
      repeat (8) @(posedge clk);
      #1;
   endtask

   task automatic send_hdr(input logic [7:0] op, input logic [23:0] a,
                           output logic oe_seen);
      logic [7:0] rx;
      logic oa, ol;
      xfer(op, 8, rx, oa, ol);
      oe_seen = oa;
      for (int k = 2; k >= 0; k--) begin
         xfer(a[k*8 +: 8], 8, rx, oa, ol);
         oe_seen = oe_seen | oa;
      end
   endtask

   // txq[0..n-1] are full bytes; txq[n] is cut after 'part' bits
   task automatic do_write(input logic [23:0] a, input int n,
                           input int part);
      logic [7:0]  rx;
      logic        oa, ol, hs;
      logic [15:0] ea;
      wq.delete();
      cs_start();
      chk("wr_busy", busy, 1);
      send_hdr(OP_WR, a, hs);
      for (int i = 0; i < n; i++) xfer(txq[i], 8, rx, oa, ol);
      if (part > 0) xfer(txq[n], part, rx, oa, ol);
      cs_end();
      chk("wr_count", wq.size(), n);
      for (int i = 0; i < n && i < wq.size(); i++) begin
         ea = 16'(a + 24'(i));
         chk("wr_addr", wq[i][23:8], ea);
         chk("wr_data", wq[i][7:0], txq[i]);
      end
      for (int i = 0; i < n; i++) ref_mem[16'(a + 24'(i))] = txq[i];
      chk("wr_idle", busy, 0);
   endtask

   task automatic do_read(input logic [23:0] a, input int n);
      logic [7:0] rx;
      logic       oa, ol, hs;
      rdq.delete();
      cs_start();
      send_hdr(OP_RD, a, hs);
      chk("rd_oe_hdr", hs, 0);
      for (int i = 0; i < n; i++) begin
         xfer(8'h00, 8, rx, oa, ol);
         rdq.push_back(rx);
         chk("rd_oe_data", ol, 1);
         chk("rd_data", rx, ref_mem[16'(a + 24'(i))]);
      end
      cs_end();
      chk("rd_oe_end", miso_oe, 0);
   endtask

   task automatic chk_reset(input string pfx);
      chk({pfx, "_miso"}, miso, 0);
      chk({pfx, "_oe"}, miso_oe, 0);
      chk({pfx, "_we"}, mem_we, 0);
      chk({pfx, "_re"}, mem_re, 0);
      chk({pfx, "_addr"}, mem_addr, 0);
      chk({pfx, "_wdata"}, mem_wdata, 0);
      chk({pfx, "_busy"}, busy, 0);
      chk({pfx, "_err"}, cmd_err, 0);
   endtask

   initial begin
      logic [7:0]  rx;
      logic        oa, ol, hs;
      logic [23:0] ra;
      int          rn;

      for (int i = 0; i < 65536; i++) begin
         dev_mem[i] = 8'($urandom);
         ref_mem[i] = dev_mem[i];
      end
      rst_n = 1'b0;
      cs_n  = 1'b1;
      sclk  = 1'b0;
      mosi  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset("rst");
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;

      txq = '{8'h78, 8'h56, 8'h34, 8'h12};
      do_write(24'h000010, 4, 0);
      chk("wr4_err", cmd_err, 0);

      for (int i = 0; i < 4; i++) begin
         dev_mem[16'h10 + 16'(i)] = txq[i];
         ref_mem[16'h10 + 16'(i)] = txq[i];
      end
      do_read(24'h000010, 4);
      chk("rd4_word", {rdq[0], rdq[1], rdq[2], rdq[3]}, 32'h78563412);

      txq = '{8'($urandom), 8'($urandom)};
      do_write(24'h00FFFF, 2, 0);
      do_read(24'h00FFFF, 2);
      txq = '{8'($urandom)};
      do_write(24'hAB0010, 1, 0);
      do_read(24'h000010, 1);

      for (int t = 0; t < 4; t++) begin
         ra = 24'($urandom);
         rn = int'($urandom_range(1, 5));
         txq.delete();
         for (int i = 0; i < 6; i++) txq.push_back(8'($urandom));
         do_write(ra, rn, 0);
         do_read(ra, rn);
      end
      ra = 24'($urandom);
      do_read(ra, int'($urandom_range(1, 4)));

      ra = 24'($urandom);
      txq = '{8'($urandom), 8'($urandom), 8'($urandom)};
      do_write(ra, 2, 4);
      chk("abort_oe", miso_oe, 0);
      do_read(ra, 2);
      chk("ok_err", cmd_err, 0);

      wq.delete();
      re_cnt = 0;
      oe_cnt = 0;
      cs_start();
      xfer(8'h9F, 8, rx, oa, ol);
      chk("bad_miso0", rx, 0);
      xfer(8'($urandom), 8, rx, oa, ol);
      chk("bad_miso1", rx, 0);
      xfer(8'($urandom), 8, rx, oa, ol);
      chk("bad_miso2", rx, 0);
      cs_end();
      chk("bad_we", wq.size(), 0);
      chk("bad_re", re_cnt, 0);
      chk("bad_oe", oe_cnt, 0);
      chk("bad_err", cmd_err, 1);
      do_read(24'h000010, 2);
      chk("bad_err_sticky", cmd_err, 1);

      ra = 24'($urandom);
      cs_start();
      send_hdr(OP_RD, ra, hs);
      xfer(8'h00, 8, rx, oa, ol);
      chk("mid_rd_byte", rx, ref_mem[ra[15:0]]);
      xfer(8'h00, 3, rx, oa, ol);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk_reset("midrst");
      rst_n = 1'b1;
      cs_n  = 1'b1;
      sclk  = 1'b0;
      mosi  = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      do_read(ra, 3);

      chk("miso_off", miso_bad, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
